life_grid: RTL and testbench
============================

// Module: life_grid
// PURPOSE
//  Parametrised Conway's Life engine (rule B3/S23) holding an NX x NY cell grid in flops.
//  - Edge mode is selectable: dead boundary or toroidal wrap.
//  - A command port clears the grid or writes single cells.
//  - A run controller steps the grid by a programmed number of generations, or until
//    stable or halted; a registered random-access read port sits alongside.
//  - Successor to the fixed-size dead-edge PE array.
//  - Sits between the host command/display logic and the frame scan-out.
// PARAMETERS
//  NX     16  grid columns (>=3)
//  NY     16  grid rows (>=3)
//  WRAP   0   0 = cells outside grid are dead; 1 = toroidal neighbours
//  GEN_W  16  width of generation target/counter
//  XW = $clog2(NX), YW = $clog2(NY) (localparams)
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      command accepted when valid & ready
//  cmd        in   2      life_cmd_t: CLEAR=0, WRITE=1, RUN=2, HALT=3
//  wr_x       in   XW     WRITE column
//  wr_y       in   YW     WRITE row
//  wr_data    in   1      WRITE cell value
//  run_gens   in   GEN_W  RUN target generations; 0 = run until stable or HALT
//  rd_x       in   XW     read column
//  rd_y       in   YW     read row
//  rd_data    out  1      registered cell value
//  busy       out  1      controller in RUN
//  done       out  1      1-cycle pulse when a RUN ends
//  gen_count  out  GEN_W  generations completed in current/last RUN
//  any_alive  out  1      registered OR of all cells
//  stable     out  1      last generation changed no cell
// BEHAVIOUR
//  - Reset:
//    - All cells 0; FSM to IDLE.
//    - busy, done, gen_count, rd_data, any_alive and stable all 0.
//    - Reset wins over any command in the same cycle; it aborts a RUN with no done pulse.
//  - FSM states and transitions:
//    - IDLE --RUN--> RUN
//    - RUN --(end)--> DONE
//    - DONE --> IDLE after 1 cycle. done=1 only in DONE.
//  - cmd_ready:
//    - 1 in IDLE.
//    - In RUN, 1 only when cmd==HALT.
//    - 0 in DONE.
//  - CLEAR: all cells 0, gen_count 0, stable 0, at the next edge.
//  - WRITE:
//    - Cell (wr_x,wr_y) <= wr_data at the next edge; stable <= 0.
//    - Out-of-range address: write ignored.
//  - RUN accept:
//    - Latch run_gens; gen_count <= 0; stable <= 0.
//    - busy=1 from the next cycle.
//  - Each RUN cycle:
//    - Every cell updates concurrently from the 8 neighbours' previous values.
//    - Neighbour count is 4 bits. Birth on 3; survive on 2 or 3; else dead.
//    - gen_count += 1, saturating at all-ones.
//    - stable <= (no cell changed this generation).
//  - RUN ends after the generation in which any of these holds:
//    - gen_count reaches the latched target (target != 0);
//    - stable becomes 1 (any target);
//    - HALT accepted.
//    If several coincide, that generation completes and done pulses once.
//  - HALT: accepted in IDLE as a no-op, with no done pulse.
//  - WRAP=1: neighbour indices mod NX / mod NY.
//  - WRAP=0: any off-grid neighbour reads 0.
//  - Read port:
//    - rd_data <= cell(rd_x,rd_y) every cycle, in any state; 1-cycle latency.
//    - Shows the grid as of the previous edge; out of range reads 0.
//  - any_alive: registered, reflects the grid after the last edge.
// STRUCTURE
//  - life_pkg:
//    - life_cmd_t enum;
//    - life_state_t enum (IDLE, RUN, DONE);
//    - NBR_W=4 constant;
//    - the B3/S23 next-state function.
//  - Sub-module life_cell:
//    - One cell flop with clear, write-enable and step-enable.
//    - Inputs: 8 neighbour bits. Outputs: state and a changed flag.
//    - life_grid wraps a generate array of these with the edge-mode neighbour mapping,
//      the FSM, the read mux and OR-reduction trees.
// TESTING
//  - Reset mid-RUN (target 100, at gen 10): next cycle busy=0, gen_count=0, all reads 0,
//    done never pulses.
//  - Blinker at (5,4),(5,5),(5,6), RUN 1: live cells exactly (4,5),(5,5),(6,5);
//    gen_count=1; done for 1 cycle; stable=0.
//  - 2x2 block at (3,3)-(4,4), RUN 0: ends after 1 generation; stable=1; gen_count=1;
//    block unchanged.
//  - WRAP=0, blinker at (0,0),(1,0),(2,0), RUN 1: live cells exactly (1,0),(1,1).
//  - WRAP=1, 16x16, glider, RUN 64: grid identical to the start; gen_count=64; stable=0.
//  - Blinker, RUN 0, HALT at gen 7: gen_count=7 or 8 (HALT-cycle generation completes);
//    single done pulse; cmd_ready low for CLEAR/WRITE while busy.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: command/state encodings and the B3/S23 next-state rule shared by the life grid.
package life_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_HALT  = 2'd3
    } life_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } life_state_t;

    localparam int NBR_W = 4;

    function automatic logic life_next(input logic alive, input logic [NBR_W-1:0] nbrs);
        return (nbrs == NBR_W'(3)) || (alive && nbrs == NBR_W'(2));
    endfunction

endpackage

// File: rtl/life_grid_if.sv
// life_grid_if: host command port of the life grid (valid/ready handshake plus operands).
interface life_grid_if #(
    parameter int XW    = 4,
    parameter int YW    = 4,
    parameter int GEN_W = 16
);
    import life_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    life_cmd_t        cmd;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic             wr_data;
    logic [GEN_W-1:0] run_gens;

    modport master (output cmd_valid, cmd, wr_x, wr_y, wr_data, run_gens, input cmd_ready);
    modport slave  (input cmd_valid, cmd, wr_x, wr_y, wr_data, run_gens, output cmd_ready);

endinterface

// File: rtl/life_cell.sv
// life_cell: one Life cell flop with clear, direct write and generation step.
module life_cell
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       wr_en,
    input  logic       wr_data,
    input  logic       step,
    input  logic [7:0] nbrs,
    output logic       state,
    output logic       changed
);

    logic [NBR_W-1:0] count;
    logic             next;

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) count = count + NBR_W'(nbrs[i]);
        next    = life_next(state, count);
        changed = next != state;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) state <= 1'b0;
        else if (wr_en)     state <= wr_data;
        else if (step)      state <= next;
    end

endmodule

// File: rtl/life_grid.sv
// life_grid: NX x NY Conway B3/S23 engine with command port, run controller and registered read port.
module life_grid
    import life_pkg::*;
#(
    parameter  int NX    = 16,
    parameter  int NY    = 16,
    parameter  int WRAP  = 0,
    parameter  int GEN_W = 16,
    localparam int XW    = $clog2(NX),
    localparam int YW    = $clog2(NY)
) (
    input  logic             clk,
    input  logic             reset,
    life_grid_if.slave       bus,
    input  logic [XW-1:0]    rd_x,
    input  logic [YW-1:0]    rd_y,
    output logic             rd_data,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             any_alive,
    output logic             stable
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]              state;
    logic [GEN_W-1:0]        target;
    logic [GEN_W-1:0]        gen_next;
    logic [NY-1:0][NX-1:0]   cells;
    logic [NY-1:0][NX-1:0]   changed;
    logic accept, step, clear_all, wr_hit, halt, stable_next, run_end, rd_hit;

    assign bus.cmd_ready = state == IDLE || (state == RUN && bus.cmd == CMD_HALT);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign step          = state == RUN;
    assign clear_all     = accept && state == IDLE && bus.cmd == CMD_CLEAR;
    assign wr_hit        = accept && state == IDLE && bus.cmd == CMD_WRITE &&
                           {1'b0, bus.wr_x} < (XW+1)'(NX) && {1'b0, bus.wr_y} < (YW+1)'(NY);
    assign halt          = accept && step;
    assign gen_next      = &gen_count ? gen_count : gen_count + 1'b1;
    assign stable_next   = ~|changed;
    assign run_end       = (|target && gen_next == target) || stable_next || halt;
    assign rd_hit        = {1'b0, rd_x} < (XW+1)'(NX) && {1'b0, rd_y} < (YW+1)'(NY);
    assign busy          = step;
    assign done          = state == DONE;

    for (genvar y = 0; y < NY; y++) begin : g_row
        for (genvar x = 0; x < NX; x++) begin : g_col
            logic [7:0] nbrs;
            for (genvar k = 0; k < 8; k++) begin : g_nbr
                // k walks the 3x3 window row-major, skipping the centre
                localparam int D  = k < 4 ? k : k + 1;
                localparam int CX = WRAP != 0 ? (x + D % 3 - 1 + NX) % NX : x + D % 3 - 1;
                localparam int CY = WRAP != 0 ? (y + D / 3 - 1 + NY) % NY : y + D / 3 - 1;
                if (CX >= 0 && CX < NX && CY >= 0 && CY < NY) begin : g_on
                    assign nbrs[k] = cells[CY][CX];
                end else begin : g_off
                    assign nbrs[k] = 1'b0;
                end
            end
            life_cell u_cell (
                .clk,
                .reset,
                .clear   (clear_all),
                .wr_en   (wr_hit && bus.wr_x == XW'(x) && bus.wr_y == YW'(y)),
                .wr_data (bus.wr_data),
                .step,
                .nbrs,
                .state   (cells[y][x]),
                .changed (changed[y][x])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            rd_data   <= 1'b0;
            any_alive <= 1'b0;
        end else begin
            rd_data   <= rd_hit && cells[rd_y][rd_x];
            any_alive <= |cells;
            if (state == IDLE && accept) begin
                if (bus.cmd != CMD_HALT) stable <= 1'b0;
                if (bus.cmd == CMD_CLEAR || bus.cmd == CMD_RUN) gen_count <= '0;
                if (bus.cmd == CMD_RUN) begin
                    target <= bus.run_gens;
                    state  <= RUN;
                end
            end else if (state == RUN) begin
                gen_count <= gen_next;
                stable    <= stable_next;
                if (run_end) state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_life_grid.sv
// tb_life_grid: scoreboard bench driving a dead-edge and a toroidal 16x16 grid with shared stimulus.
module tb_life_grid;
    import life_pkg::*;

    typedef struct packed {logic [15:0] g; logic s;} done_t;
    typedef struct {int x; int y; bit v0; bit v1;} rd_t;

    logic clk = 0, reset = 1;
    logic cmd_valid = 0;
    life_cmd_t cmd = CMD_CLEAR;
    logic [3:0] wr_x = 0, wr_y = 0, rd_x = 0, rd_y = 0;
    logic wr_data = 0;
    logic [15:0] run_gens = 0;
    logic rd_data0, busy0, done0, any_alive0, stable0, cmd_ready0;
    logic rd_data1, busy1, done1, any_alive1, stable1, cmd_ready1;
    logic [15:0] gen_count0, gen_count1;

    int n_chk = 0, n_pass = 0;
    bit m [2][16][16];
    done_t q_done0[$], q_done1[$];
    done_t e0, e1;
    rd_t q_rd[$];
    rd_t r;
    logic rd_tag = 0, rd_tag_d = 0;

    always #5 clk = ~clk;

    life_grid_if #(.XW(4), .YW(4), .GEN_W(16)) bus0 ();
    life_grid_if #(.XW(4), .YW(4), .GEN_W(16)) bus1 ();

    assign bus0.cmd_valid = cmd_valid;
    assign bus0.cmd       = cmd;
    assign bus0.wr_x      = wr_x;
    assign bus0.wr_y      = wr_y;
    assign bus0.wr_data   = wr_data;
    assign bus0.run_gens  = run_gens;
    assign cmd_ready0     = bus0.cmd_ready;
    assign bus1.cmd_valid = cmd_valid;
    assign bus1.cmd       = cmd;
    assign bus1.wr_x      = wr_x;
    assign bus1.wr_y      = wr_y;
    assign bus1.wr_data   = wr_data;
    assign bus1.run_gens  = run_gens;
    assign cmd_ready1     = bus1.cmd_ready;

    life_grid #(.NX(16), .NY(16), .WRAP(0), .GEN_W(16)) u0 (
        .clk(clk), .reset(reset), .bus(bus0), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .gen_count(gen_count0), .any_alive(any_alive0), .stable(stable0));

    life_grid #(.NX(16), .NY(16), .WRAP(1), .GEN_W(16)) u1 (
        .clk(clk), .reset(reset), .bus(bus1), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .gen_count(gen_count1), .any_alive(any_alive1), .stable(stable1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: Life rules straight from neighbour counting on a plain array.
    task automatic model_step(input int w, output bit chg);
        bit nxt [16][16];
        chg = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) begin
                            int cx = x + dx, cy = y + dy;
                            if (w == 1) begin cx = (cx + 16) % 16; cy = (cy + 16) % 16; end
                            if (cx >= 0 && cx < 16 && cy >= 0 && cy < 16) n += int'(m[w][cy][cx]);
                        end
                nxt[y][x] = (n == 3) || (m[w][y][x] && n == 2);
                if (nxt[y][x] != m[w][y][x]) chg = 1;
            end
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) m[w][y][x] = nxt[y][x];
    endtask

    task automatic run_model(input int w, input int target, input int halt_gen);
        int g = 0;
        bit chg, st = 0;
        for (int i = 0; i < 70000; i++) begin
            model_step(w, chg);
            st = !chg;
            g = g == 65535 ? g : g + 1;
            if ((target != 0 && g == target) || st || (halt_gen != 0 && g == halt_gen)) break;
        end
        if (w == 0) q_done0.push_back({16'(g), st});
        else q_done1.push_back({16'(g), st});
    endtask

    function automatic bit model_any(input int w);
        bit a = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) a |= m[w][y][x];
        return a;
    endfunction

    task automatic model_clear();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin m[0][y][x] = 0; m[1][y][x] = 0; end
    endtask

    task automatic issue(input life_cmd_t c, input int x = 0, input int y = 0, input int d = 0, input int g = 0);
        @(negedge clk);
        cmd = c; wr_x = 4'(x); wr_y = 4'(y); wr_data = 1'(d); run_gens = 16'(g); cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic do_clear();
        issue(CMD_CLEAR);
        model_clear();
    endtask

    task automatic do_write(input int x, input int y, input int d);
        issue(CMD_WRITE, x, y, d);
        m[0][y][x] = 1'(d);
        m[1][y][x] = 1'(d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1 || done0 || done1) && n < 5000) begin @(negedge clk); n++; end
        chk("run_finishes", n < 5000, 1);
    endtask

    task automatic do_run(input int t);
        run_model(0, t, 0);
        run_model(1, t, 0);
        issue(CMD_RUN, 0, 0, 0, t);
        wait_idle();
    endtask

    task automatic read_cell(input int x, input int y);
        @(negedge clk);
        rd_x = 4'(x); rd_y = 4'(y); rd_tag = 1;
        q_rd.push_back('{x, y, m[0][y][x], m[1][y][x]});
    endtask

    task automatic scan();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) read_cell(x, y);
        @(negedge clk);
        rd_tag = 0;
        @(negedge clk);
        chk("any_alive0", any_alive0, model_any(0));
        chk("any_alive1", any_alive1, model_any(1));
    endtask

    always @(posedge clk) rd_tag_d <= rd_tag;

    always @(negedge clk) begin
        if (rd_tag_d && q_rd.size() > 0) begin
            r = q_rd.pop_front();
            chk($sformatf("rd0(%0d,%0d)", r.x, r.y), rd_data0, r.v0);
            chk($sformatf("rd1(%0d,%0d)", r.x, r.y), rd_data1, r.v1);
        end
    end

    always @(negedge clk) begin
        if (done0) begin
            if (q_done0.size() == 0) begin
                n_chk++;
                $display("FAIL done0: unexpected pulse gen_count=%0d", gen_count0);
            end else begin
                e0 = q_done0.pop_front();
                chk("gen_count0", gen_count0, e0.g);
                chk("stable0", stable0, e0.s);
            end
        end
        if (done1) begin
            if (q_done1.size() == 0) begin
                n_chk++;
                $display("FAIL done1: unexpected pulse gen_count=%0d", gen_count1);
            end else begin
                e1 = q_done1.pop_front();
                chk("gen_count1", gen_count1, e1.g);
                chk("stable1", stable1, e1.s);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_busy0", busy0, 0);
        chk("reset_done0", done0, 0);
        chk("reset_gen0", gen_count0, 0);
        chk("reset_stable0", stable0, 0);
        chk("reset_alive1", any_alive1, 0);
        chk("reset_rd1", rd_data1, 0);
        chk("reset_ready0", cmd_ready0, 1);
        reset = 0;
        scan();

        // vertical blinker flips to horizontal
        do_clear();
        do_write(5, 4, 1); do_write(5, 5, 1); do_write(5, 6, 1);
        do_run(1);
        scan();

        // still-life block stops a RUN 0 after one generation
        do_clear();
        do_write(3, 3, 1); do_write(4, 3, 1); do_write(3, 4, 1); do_write(4, 4, 1);
        do_run(0);
        scan();

        // blinker on the top edge: dead boundary vs wrap
        do_clear();
        do_write(0, 0, 1); do_write(1, 0, 1); do_write(2, 0, 1);
        do_run(1);
        scan();

        // glider over 64 generations
        do_clear();
        do_write(6, 5, 1); do_write(7, 6, 1); do_write(5, 7, 1); do_write(6, 7, 1); do_write(7, 7, 1);
        do_run(64);
        scan();

        // HALT at gen 7: the HALT-cycle generation completes
        do_clear();
        do_write(5, 4, 1); do_write(5, 5, 1); do_write(5, 6, 1);
        run_model(0, 0, 8);
        run_model(1, 0, 8);
        issue(CMD_RUN, 0, 0, 0, 0);
        chk("busy_after_run0", busy0, 1);
        cmd = CMD_CLEAR; #1;
        chk("ready_clear_busy0", cmd_ready0, 0);
        chk("ready_clear_busy1", cmd_ready1, 0);
        cmd = CMD_WRITE; #1;
        chk("ready_write_busy0", cmd_ready0, 0);
        repeat (7) @(negedge clk);
        chk("gen_before_halt0", gen_count0, 7);
        chk("gen_before_halt1", gen_count1, 7);
        cmd = CMD_HALT; cmd_valid = 1; #1;
        chk("ready_halt_busy0", cmd_ready0, 1);
        chk("ready_halt_busy1", cmd_ready1, 1);
        @(negedge clk);
        cmd_valid = 0;
        wait_idle();
        scan();

        // HALT while idle is a no-op
        issue(CMD_HALT);
        repeat (3) @(negedge clk);
        chk("halt_idle_gen0", gen_count0, 8);
        chk("halt_idle_busy1", busy1, 0);

        // reset mid-RUN aborts without done
        do_clear();
        do_write(5, 4, 1); do_write(5, 5, 1); do_write(5, 6, 1);
        issue(CMD_RUN, 0, 0, 0, 100);
        repeat (10) @(negedge clk);
        chk("gen_before_reset0", gen_count0, 10);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort_busy0", busy0, 0);
        chk("abort_busy1", busy1, 0);
        chk("abort_gen0", gen_count0, 0);
        chk("abort_gen1", gen_count1, 0);
        model_clear();
        scan();

        // random soups with random targets
        for (int it = 0; it < 5; it++) begin
            do_clear();
            for (int i = 0; i < 40; i++)
                do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3) != 0));
            do_run(int'($urandom_range(1, 15)));
            scan();
        end

        repeat (3) @(negedge clk);
        chk("done_q0_drained", q_done0.size(), 0);
        chk("done_q1_drained", q_done1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
